// File: rtl/player_move_ctrl.sv
// player_move_ctrl: PS/2 scan-code driven movement controller for up to two
// players. Decodes make/break/extended byte sequences into per-player held-key
// sets, runs a movement FSM per player, steps saturating X/Y positions on a
// programmable tick and latches game-over on bullet hits.
module player_move_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 8,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int STEP_DIV    = 500000,
  parameter int X_START0    = 8,
  parameter int Y_START0    = 60,
  parameter int X_START1    = 151,
  parameter int Y_START1    = 60
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [7:0]                   ps2_data,
  input  logic                         ps2_valid,
  input  logic                         restart,
  input  logic [NUM_PLAYERS-1:0]       bullet_hit,
  output logic [4*NUM_PLAYERS-1:0]     currentState,
  output logic [NUM_PLAYERS-1:0]       northEnable,
  output logic [NUM_PLAYERS-1:0]       eastEnable,
  output logic [NUM_PLAYERS-1:0]       southEnable,
  output logic [NUM_PLAYERS-1:0]       westEnable,
  output logic [POS_W*NUM_PLAYERS-1:0] pos_x,
  output logic [POS_W*NUM_PLAYERS-1:0] pos_y,
  output logic                         step_tick
);

  typedef enum logic [3:0] {
    IDLE         = 4'h0,
    MOVING_NORTH = 4'h1,
    MOVING_EAST  = 4'h2,
    MOVING_SOUTH = 4'h3,
    MOVING_WEST  = 4'h4,
    GAME_OVER    = 4'hF
  } state_t;

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);

  // Direction index 0..3 = N, E, S, W.
  function automatic state_t dir_state(input logic [1:0] d);
    case (d)
      2'd0:    return MOVING_NORTH;
      2'd1:    return MOVING_EAST;
      2'd2:    return MOVING_SOUTH;
      default: return MOVING_WEST;
    endcase
  endfunction

  // Highest-priority held direction, N > E > S > W.
  function automatic state_t resolve(input logic [3:0] h);
    if (h[0])      return MOVING_NORTH;
    else if (h[1]) return MOVING_EAST;
    else if (h[2]) return MOVING_SOUTH;
    else if (h[3]) return MOVING_WEST;
    else           return IDLE;
  endfunction

  logic [CW-1:0] cnt;
  logic          ext, brk;
  logic          is_key, map0, map1;
  logic [1:0]    dir0, dir1;
  logic [1:0]    key_hit;
  logic [1:0]    key_dir [2];

  // Step divider, realigned by restart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              cnt <= '0;
    else if (restart)         cnt <= '0;
    else if (cnt == DIV_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign step_tick = (cnt == DIV_LAST) && !restart;

  // Prefix flags accumulate until a key byte, which clears both.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (restart) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (ps2_valid) begin
      case (ps2_data)
        8'hE0:   ext <= 1'b1;
        8'hF0:   brk <= 1'b1;
        default: begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

  // Keymap lookup for both players.
  always_comb begin
    is_key = ps2_valid && (ps2_data != 8'hE0) && (ps2_data != 8'hF0);
    map0 = 1'b0;
    dir0 = 2'd0;
    map1 = 1'b0;
    dir1 = 2'd0;
    case (ps2_data)
      8'h1D:   begin map0 = 1'b1; dir0 = 2'd0; end
      8'h23:   begin map0 = 1'b1; dir0 = 2'd1; end
      8'h1B:   begin map0 = 1'b1; dir0 = 2'd2; end
      8'h1C:   begin map0 = 1'b1; dir0 = 2'd3; end
      default: ;
    endcase
    case (ps2_data)
      8'h75:   begin map1 = 1'b1; dir1 = 2'd0; end
      8'h74:   begin map1 = 1'b1; dir1 = 2'd1; end
      8'h72:   begin map1 = 1'b1; dir1 = 2'd2; end
      8'h6B:   begin map1 = 1'b1; dir1 = 2'd3; end
      default: ;
    endcase
  end

  assign key_hit[0] = is_key && !ext && map0;
  assign key_hit[1] = is_key && ext && map1 && (NUM_PLAYERS == 2);
  assign key_dir[0] = dir0;
  assign key_dir[1] = dir1;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    localparam logic [POS_W-1:0] XS = POS_W'((p == 0) ? X_START0 : X_START1);
    localparam logic [POS_W-1:0] YS = POS_W'((p == 0) ? Y_START0 : Y_START1);

    state_t           st;
    state_t           key_st;
    logic [3:0]       held, held_nx;
    logic [POS_W-1:0] x, y;

    assign key_st = dir_state(key_dir[p]);

    // Held set as it will be after this cycle's key byte.
    always_comb begin
      held_nx = held;
      if (key_hit[p]) held_nx[key_dir[p]] = !brk;
    end

    // Movement FSM and position; moves use the pre-update state.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        st   <= IDLE;
        held <= '0;
        x    <= XS;
        y    <= YS;
      end else if (restart) begin
        st   <= IDLE;
        held <= '0;
        x    <= XS;
        y    <= YS;
      end else begin
        if (step_tick) begin
          case (st)
            MOVING_NORTH: if (y != '0)   y <= y - 1'b1;
            MOVING_SOUTH: if (y < Y_LIM) y <= y + 1'b1;
            MOVING_EAST:  if (x < X_LIM) x <= x + 1'b1;
            MOVING_WEST:  if (x != '0)   x <= x - 1'b1;
            default: ;
          endcase
        end
        if (st != GAME_OVER) begin
          held <= held_nx;
          if (bullet_hit[p]) begin
            st <= GAME_OVER;
          end else if (key_hit[p]) begin
            if (!brk)              st <= key_st;
            else if (st == key_st) st <= resolve(held_nx);
          end
        end
      end
    end

    assign currentState[4*p +: 4]   = st;
    assign northEnable[p]           = (st == MOVING_NORTH);
    assign eastEnable[p]            = (st == MOVING_EAST);
    assign southEnable[p]           = (st == MOVING_SOUTH);
    assign westEnable[p]            = (st == MOVING_WEST);
    assign pos_x[POS_W*p +: POS_W]  = x;
    assign pos_y[POS_W*p +: POS_W]  = y;
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Testbench for player_move_ctrl: table of {byte, hit, restart, expected
// states} records plus hand sequences; a position/tick model feeds a queue of
// expected outputs that is checked one cycle after each stimulus.
module tb_player_move_ctrl;
  localparam int NP = 2;
  localparam int PW = 8;
  localparam int XM = 159;
  localparam int YM = 119;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    ps2_data;
  logic          ps2_valid;
  logic          restart;
  logic [NP-1:0] bullet_hit;
  logic [4*NP-1:0]  currentState;
  logic [NP-1:0]    northEnable, eastEnable, southEnable, westEnable;
  logic [PW*NP-1:0] pos_x, pos_y;
  logic             step_tick;

  always #5 clk = ~clk;

  player_move_ctrl #(
    .NUM_PLAYERS(NP), .POS_W(PW), .X_MAX(XM), .Y_MAX(YM), .STEP_DIV(SD),
    .X_START0(8), .Y_START0(60), .X_START1(151), .Y_START1(60)
  ) dut (
    .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .restart(restart), .bullet_hit(bullet_hit), .currentState(currentState),
    .northEnable(northEnable), .eastEnable(eastEnable),
    .southEnable(southEnable), .westEnable(westEnable),
    .pos_x(pos_x), .pos_y(pos_y), .step_tick(step_tick)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [1:0] hit;
    logic       rst;
    logic [3:0] s0;
    logic [3:0] s1;
    int         rep;
  } vec_t;

  typedef struct {
    logic [3:0] s0, s1;
    int x0, y0, x1, y1;
    int idx;
  } exp_t;

  vec_t vecs[$];
  exp_t q[$];
  int ncmp = 0;
  int nfail = 0;
  int m_cnt;
  int mx[2], my[2];
  logic [3:0] ms[2];

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s (vec %0d): got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic int en_of(input logic [3:0] s);
    if (s >= 4'd1 && s <= 4'd4) return 1 << (s - 1);
    return 0;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    mx[0] = 8;   my[0] = 60;
    mx[1] = 151; my[1] = 60;
    ms[0] = 4'h0; ms[1] = 4'h0;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [1:0] h,
                     input logic r, input logic [3:0] s0, input logic [3:0] s1,
                     input int rep);
    vec_t e;
    e.valid = v; e.data = d; e.hit = h; e.rst = r; e.s0 = s0; e.s1 = s1; e.rep = rep;
    vecs.push_back(e);
  endtask

  task automatic key(input logic [7:0] d, input logic [3:0] s0, input logic [3:0] s1);
    add(1'b1, d, 2'b00, 1'b0, s0, s1, 1);
  endtask

  task automatic idle(input int n, input logic [3:0] s0, input logic [3:0] s1);
    add(1'b0, 8'h00, 2'b00, 1'b0, s0, s1, n);
  endtask

  // Pop the oldest expectation and compare against the DUT outputs.
  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", -1, 1, 0);
      return;
    end
    e = q.pop_front();
    chk("state0", e.idx, int'(currentState[3:0]), int'(e.s0));
    chk("state1", e.idx, int'(currentState[7:4]), int'(e.s1));
    chk("x0", e.idx, int'(pos_x[7:0]),  e.x0);
    chk("y0", e.idx, int'(pos_y[7:0]),  e.y0);
    chk("x1", e.idx, int'(pos_x[15:8]), e.x1);
    chk("y1", e.idx, int'(pos_y[15:8]), e.y1);
    chk("enables0", e.idx,
        int'({westEnable[0], southEnable[0], eastEnable[0], northEnable[0]}), en_of(e.s0));
    chk("enables1", e.idx,
        int'({westEnable[1], southEnable[1], eastEnable[1], northEnable[1]}), en_of(e.s1));
  endtask

  // Entered at a falling edge; drives one cycle and leaves at the next one.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    bit tick;
    ps2_valid = v.valid; ps2_data = v.data; bullet_hit = v.hit; restart = v.rst;
    #1;
    tick = (m_cnt == SD - 1) && !v.rst;
    chk("step_tick", idx, int'(step_tick), int'(tick));
    if (v.rst) begin
      model_reset();
    end else begin
      if (tick) begin
        for (int p = 0; p < 2; p++) begin
          case (ms[p])
            4'h1: if (my[p] > 0)  my[p]--;
            4'h2: if (mx[p] < XM) mx[p]++;
            4'h3: if (my[p] < YM) my[p]++;
            4'h4: if (mx[p] > 0)  mx[p]--;
            default: ;
          endcase
        end
      end
      m_cnt = (m_cnt == SD - 1) ? 0 : m_cnt + 1;
    end
    ms[0] = v.s0; ms[1] = v.s1;
    e.s0 = v.s0; e.s1 = v.s1;
    e.x0 = mx[0]; e.y0 = my[0]; e.x1 = mx[1]; e.y1 = my[1];
    e.idx = idx;
    q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic run_vecs(input int base);
    for (int i = 0; i < vecs.size(); i++)
      for (int r = 0; r < vecs[i].rep; r++)
        apply(vecs[i], base + i);
    vecs.delete();
  endtask

  initial begin
    resetn = 1'b0; ps2_data = '0; ps2_valid = 1'b0; restart = 1'b0; bullet_hit = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_state", 0, int'(currentState), 0);
    chk("rst_x", 0, int'(pos_x), (151 << 8) | 8);
    chk("rst_y", 0, int'(pos_y), (60 << 8) | 60);
    chk("rst_tick", 0, int'(step_tick), 0);
    resetn = 1'b1;

    // Basic press/release with movement.
    key(8'h1D, 1, 0); idle(8, 1, 0); key(8'hF0, 1, 0); key(8'h1D, 0, 0); idle(5, 0, 0);
    // Latest press wins, release falls back to held.
    key(8'h1D, 1, 0); key(8'h23, 2, 0); key(8'hF0, 2, 0); key(8'h23, 1, 0);
    key(8'hF0, 1, 0); key(8'h1D, 0, 0);
    // Typematic repeat and break of a non-current direction.
    key(8'h1D, 1, 0); key(8'h1D, 1, 0); key(8'h23, 2, 0); key(8'hF0, 2, 0);
    key(8'h1D, 2, 0); key(8'hF0, 2, 0); key(8'h23, 0, 0);
    // Fallback priority S over W.
    key(8'h1B, 3, 0); key(8'h1C, 4, 0); key(8'h23, 2, 0); key(8'hF0, 2, 0);
    key(8'h23, 3, 0); key(8'hF0, 3, 0); key(8'h1B, 4, 0); key(8'hF0, 4, 0);
    key(8'h1C, 0, 0);
    // Extended keys, unmapped extended byte, flags clearing.
    key(8'hE0, 0, 0); key(8'h74, 0, 2); idle(4, 0, 2); key(8'hE0, 0, 2);
    key(8'hF0, 0, 2); key(8'h74, 0, 0); key(8'hE0, 0, 0); key(8'h1D, 0, 0);
    key(8'h1D, 1, 0); key(8'hF0, 1, 0); key(8'hE0, 1, 0); key(8'h75, 1, 0);
    key(8'hF0, 1, 0); key(8'h1D, 0, 0);
    // F0 E0 prefix order, unmapped plain byte after break.
    key(8'hE0, 0, 0); key(8'h6B, 0, 4); key(8'hF0, 0, 4); key(8'hE0, 0, 4);
    key(8'h6B, 0, 0); key(8'hF0, 0, 0); key(8'h15, 0, 0); key(8'h1D, 1, 0);
    // Game over, sticky, restart priority.
    idle(6, 1, 0); add(1'b0, 8'h00, 2'b01, 1'b0, 4'hF, 0, 1); idle(6, 4'hF, 0);
    key(8'h1B, 4'hF, 0); add(1'b0, 8'h00, 2'b00, 1'b1, 0, 0, 1);
    add(1'b1, 8'h1D, 2'b01, 1'b0, 4'hF, 0, 1);
    add(1'b0, 8'h00, 2'b10, 1'b0, 4'hF, 4'hF, 1);
    add(1'b1, 8'h1D, 2'b00, 1'b1, 0, 0, 1); idle(3, 0, 0);
    key(8'hE0, 0, 0); key(8'h72, 0, 3); idle(5, 0, 3);
    add(1'b0, 8'h00, 2'b11, 1'b1, 0, 0, 1); idle(2, 0, 0);
    run_vecs(1);

    // Saturation at both X edges.
    key(8'h1C, 4, 0); key(8'hE0, 4, 0); key(8'h74, 4, 2); idle(100, 4, 2);
    run_vecs(1000);
    chk("sat_x0", 1100, int'(pos_x[7:0]), 0);
    chk("sat_x1", 1100, int'(pos_x[15:8]), XM);
    key(8'hF0, 4, 2); key(8'h1C, 0, 2); key(8'hE0, 0, 2); key(8'hF0, 0, 2);
    key(8'h74, 0, 0); key(8'hF0, 0, 0);
    run_vecs(2000);

    // Asynchronous reset discards a pending break prefix.
    resetn = 1'b0;
    #1;
    chk("async_state", 3000, int'(currentState), 0);
    chk("async_x", 3000, int'(pos_x), (151 << 8) | 8);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    key(8'h1D, 1, 0); idle(3, 1, 0);
    run_vecs(3001);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end
endmodule
